// File: rtl/ddr_dummy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_dummy_responder
//  Purpose  : DDR-side stand-in for the cache memory port; fixed-latency
//             responder backed by a small fully-associative line store.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_dummy_responder #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int DEPTH_LOG2    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [255:0]          mem_data_wr1,
  input  logic [27:0]           mem_data_addr1,
  input  logic                  mem_rw_data1,
  input  logic                  mem_valid_data1,
  output logic [255:0]          mem_data_rd1,
  output logic                  mem_ready_data1,
  output logic                  rd_miss,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic                  proto_err
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [27:0]            cmd_addr_q;
  logic [255:0]           cmd_data_q;
  logic                   cmd_rw_q;
  logic [255:0]           rd_data_q;
  logic                   ready_q;
  logic                   rd_miss_q;
  logic [DEPTH_LOG2:0]    occ_q;
  logic [15:0]            wr_cnt_q;
  logic [15:0]            rd_cnt_q;
  logic                   perr_q;
  logic [DEPTH_LOG2-1:0]  alloc_ptr_q;
  logic [DEPTH-1:0]       ent_vld_q;
  logic [27:0]            ent_addr_q [DEPTH];
  logic [255:0]           ent_data_q [DEPTH];

  logic                   w_hit;
  logic [DEPTH_LOG2-1:0]  w_hit_idx;
  logic                   w_free;
  logic [DEPTH_LOG2-1:0]  w_free_idx;
  logic [DEPTH_LOG2-1:0]  w_wr_idx;
  logic                   w_done;
  logic                   w_commit_wr;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_vld_q[i] && (ent_addr_q[i] == cmd_addr_q)) begin
        w_hit     = 1'b1;
        w_hit_idx = DEPTH_LOG2'(i);
      end
      if (!ent_vld_q[i]) begin
        w_free     = 1'b1;
        w_free_idx = DEPTH_LOG2'(i);
      end
    end
  end

  assign w_wr_idx    = w_hit ? w_hit_idx : (w_free ? w_free_idx : alloc_ptr_q);
  assign w_done      = (state_q == ST_BUSY) && (cnt_q == '0);
  assign w_commit_wr = w_done && cmd_rw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_rw_q    <= 1'b0;
      rd_data_q   <= '0;
      ready_q     <= 1'b0;
      rd_miss_q   <= 1'b0;
      occ_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      perr_q      <= 1'b0;
      alloc_ptr_q <= '0;
      ent_vld_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q   <= 1'b0;
          rd_miss_q <= 1'b0;
          if (mem_valid_data1) begin
            cmd_addr_q <= mem_data_addr1;
            cmd_data_q <= mem_data_wr1;
            cmd_rw_q   <= mem_rw_data1;
            cnt_q      <= mem_rw_data1 ? WR_CNT_INIT : RD_CNT_INIT;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!mem_valid_data1) begin
            perr_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            if (cmd_rw_q) begin
              ent_vld_q[w_wr_idx] <= 1'b1;
              wr_cnt_q            <= wr_cnt_q + 16'd1;
              if (!w_hit && w_free) begin
                occ_q <= occ_q + (DEPTH_LOG2+1)'(1);
              end
              if (!w_hit && !w_free) begin
                alloc_ptr_q <= alloc_ptr_q + DEPTH_LOG2'(1);
              end
            end else begin
              rd_data_q <= w_hit ? ent_data_q[w_hit_idx] : '0;
              rd_miss_q <= !w_hit;
              rd_cnt_q  <= rd_cnt_q + 16'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          ready_q   <= 1'b0;
          rd_miss_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Line payload carries no reset; entry validity is what the reset clears.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      ent_addr_q[w_wr_idx] <= cmd_addr_q;
      ent_data_q[w_wr_idx] <= cmd_data_q;
    end
  end

  assign mem_data_rd1    = rd_data_q;
  assign mem_ready_data1 = ready_q;
  assign rd_miss         = rd_miss_q;
  assign occupancy       = occ_q;
  assign wr_count        = wr_cnt_q;
  assign rd_count        = rd_cnt_q;
  assign proto_err       = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_dummy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_dummy_responder
//  Purpose  : Scoreboard bench for ddr_dummy_responder with a line-store model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_dummy_responder;

  localparam int RL = 4;
  localparam int WL = 2;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] wdata = '0;
  logic [27:0]  addr = '0;
  logic         rw = 1'b0;
  logic         valid = 1'b0;
  logic [255:0] rdata;
  logic         ready;
  logic         miss;
  logic [4:0]   occ;
  logic [15:0]  wrc;
  logic [15:0]  rdc;
  logic         perr;

  ddr_dummy_responder #(
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL),
    .DEPTH_LOG2    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_data_wr1    (wdata),
    .mem_data_addr1  (addr),
    .mem_rw_data1    (rw),
    .mem_valid_data1 (valid),
    .mem_data_rd1    (rdata),
    .mem_ready_data1 (ready),
    .rd_miss         (miss),
    .occupancy       (occ),
    .wr_count        (wrc),
    .rd_count        (rdc),
    .proto_err       (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference store: slots fill in order, then round-robin replacement.
  logic [27:0]  m_addr [DEPTH];
  logic [255:0] m_data [DEPTH];
  int           m_n, m_ptr, m_wrc, m_rdc;
  logic [255:0] m_rd;
  bit           m_perr;

  typedef struct {
    int           due;
    bit           is_wr;
    logic [255:0] rd;
    bit           miss;
    int           occ;
    int           wrc;
    int           rdc;
    bit           perr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    m_n = 0; m_ptr = 0; m_wrc = 0; m_rdc = 0; m_rd = '0; m_perr = 0;
    sb.delete();
  endtask

  task automatic model_cmd(input bit w, input logic [27:0] a, input logic [255:0] d, output exp_t e);
    int found;
    found = -1;
    for (int i = 0; i < m_n; i++) if (m_addr[i] == a) found = i;
    e.miss = 0;
    if (w) begin
      if (found >= 0) m_data[found] = d;
      else if (m_n < DEPTH) begin m_addr[m_n] = a; m_data[m_n] = d; m_n++; end
      else begin m_addr[m_ptr] = a; m_data[m_ptr] = d; m_ptr = (m_ptr + 1) % DEPTH; end
      m_wrc = (m_wrc + 1) & 16'hFFFF;
    end else begin
      if (found >= 0) m_rd = m_data[found];
      else begin m_rd = '0; e.miss = 1; end
      m_rdc = (m_rdc + 1) & 16'hFFFF;
    end
    e.is_wr = w; e.rd = m_rd; e.occ = m_n; e.wrc = m_wrc; e.rdc = m_rdc; e.perr = m_perr;
  endtask

  // Starts at a negedge; returns at the negedge where ready is seen, valid left
  // high when hold=1. drop=1 releases valid for one BUSY cycle.
  task automatic issue(input bit w, input logic [27:0] a, input logic [255:0] d,
                       input bit hold, input bit drop);
    exp_t e;
    bit   seen;
    @(negedge clk);
    if (drop) m_perr = 1;
    model_cmd(w, a, d, e);
    e.due = cyc + 1 + (w ? WL : RL);
    sb.push_back(e);
    rw = w; addr = a; wdata = d; valid = 1'b1;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (drop && t == 0) valid = 1'b0;
      else if (drop && t == 1) valid = 1'b1;
      if (ready) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL no_ready: got 0 expected 1 (addr %0h)", a);
    end
    if (!hold) valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  // Monitor: pops an expectation on every ready pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready: got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("ready_cycle", 256'(cyc), 256'(e.due));
            chk("rd_data", rdata, e.rd);
            chk("rd_miss", 256'(miss), 256'(e.is_wr ? 1'b0 : e.miss));
            chk("occupancy", 256'(occ), 256'(e.occ));
            chk("wr_count", 256'(wrc), 256'(e.wrc));
            chk("rd_count", 256'(rdc), 256'(e.rdc));
            chk("proto_err", 256'(perr), 256'(e.perr));
          end
        end else begin
          if (miss !== 1'b0) chk("rd_miss_idle", 256'(miss), 256'(0));
          if (sb.size() > 0 && cyc > sb[0].due) begin
            n_vec++; n_err++;
            $display("FAIL ready_late: got none expected at cycle %0d", sb[0].due);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  logic [255:0] pat, da, db;
  logic [27:0]  a17 [17];
  logic [27:0]  pool [24];

  initial begin
    model_clear();
    // 1: reset state
    do_reset();
    @(negedge clk);
    chk("rst_ready", 256'(ready), 256'(0));
    chk("rst_miss", 256'(miss), 256'(0));
    chk("rst_rdata", rdata, 256'(0));
    chk("rst_occ", 256'(occ), 256'(0));
    chk("rst_wrc", 256'(wrc), 256'(0));
    chk("rst_rdc", 256'(rdc), 256'(0));
    chk("rst_perr", 256'(perr), 256'(0));

    // 2: write then read back
    pat = {8{32'h1111_8888}};
    issue(1, 28'h0000008, pat, 0, 0);
    issue(0, 28'h0000008, '0, 0, 0);
    // 3: unwritten address misses
    issue(0, 28'h3000000, '0, 0, 0);
    // 4: write hit overwrites in place
    da = rnd256(); db = rnd256();
    issue(1, 28'h2000030, da, 0, 0);
    issue(1, 28'h2000030, db, 0, 0);
    issue(0, 28'h2000030, '0, 0, 0);

    // 5: 17 distinct writes, round-robin replacement of entry 0
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a17[i] = 28'h0100000 + 28'(i * 64);
      issue(1, a17[i], rnd256(), 0, 0);
    end
    issue(0, a17[0], '0, 0, 0);
    issue(0, a17[1], '0, 0, 0);
    issue(0, a17[16], '0, 0, 0);

    // 6: back-to-back with valid held, then dropped valid, then resets
    do_reset();
    issue(1, 28'h0000040, rnd256(), 1, 0);
    issue(0, 28'h0000040, '0, 1, 0);
    issue(1, 28'h0000080, rnd256(), 0, 0);
    issue(0, 28'h0000080, '0, 0, 1);
    issue(0, 28'h0000040, '0, 0, 0);
    rst = 1'b1;
    #1 chk("ready_async_drop", 256'(ready), 256'(0));
    sb.delete();
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    @(negedge clk);
    rw = 1'b1; addr = 28'h0000123; wdata = rnd256(); valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    #1 chk("busy_rst_ready", 256'(ready), 256'(0));
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    issue(0, 28'h0000123, '0, 0, 0);
    issue(0, 28'h0000080, '0, 0, 0);

    // Random traffic over a pool larger than the store
    do_reset();
    for (int i = 0; i < 24; i++) pool[i] = 28'($urandom);
    for (int n = 0; n < 200; n++) begin
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 23)], rnd256(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    valid = 1'b0;
    repeat (8) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
